single_port_ram_be: RTL and testbench
=====================================

Name: single_port_ram_be

Overview:
Parametrised single-port synchronous RAM with per-byte write enables and a configurable read-during-write mode. It has an optional output pipeline register and a q_valid strobe. An optional post-reset clear sequencer zeroes every word before accepting accesses. It is a drop-in storage block for buffers and register files that need partial-word writes and deterministic power-up contents.

Parameters:
ADDR_WIDTH, 6, address bits.
DATA_WIDTH, 32, word width. Must be a multiple of 8. NB = DATA_WIDTH/8 byte lanes.
DEPTH, 64, number of words. Must satisfy DEPTH <= 2**ADDR_WIDTH.
RDW_MODE, 0, read-during-write mode: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).
CLEAR_ON_RESET, 1, 1 enables the post-reset zero-fill sequencer.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  access enable.
we  input  1  write enable; qualified by en.
be  input  NB  byte enables; be[i] selects data[8i+7:8i].
addr  input  ADDR_WIDTH  word address.
data  input  DATA_WIDTH  write data.
q  output  DATA_WIDTH  read data.
q_valid  output  1  high for exactly one cycle per returned read word, aligned with q.
busy  output  1  high while clear is in progress; accesses are ignored while busy is high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - q = 0, q_valid = 0.
  - Pipeline contents are flushed; any in-flight read is lost.
  - busy = CLEAR_ON_RESET.
  - The clear FSM is forced to INIT with clear pointer = 0.
  - Memory array contents are not reset directly.
- FSM states: INIT and RUN.
  - With CLEAR_ON_RESET=0, the FSM enters RUN straight from reset.
  - INIT: writes 0 to address = pointer each cycle and increments the pointer. After writing DEPTH-1, the next state is RUN and busy falls.
  - Zero-fill takes exactly DEPTH cycles after the first rising edge with rst_n high.
  - Reset asserted during INIT restarts the clear from address 0.
- In INIT, en/we/be/addr/data are ignored: no writes, no q_valid.
- RUN, write (en=1, we=1):
  - At the rising edge, each lane with be[i]=1 takes data lane i.
  - Lanes with be[i]=0 keep their contents.
  - be = 0 still counts as an access for RDW purposes.
- RUN, read (en=1, we=0):
  - OUT_REG=0: q = mem[addr] and q_valid = 1 one cycle after the request edge.
  - OUT_REG=1: q and q_valid appear two cycles after the request edge.
  - Back-to-back reads give one result per cycle.
- Read-during-write (en=1, we=1):
  - READ_FIRST: q returns the old word with q_valid.
  - WRITE_FIRST: q returns the merged new word with q_valid.
  - NO_CHANGE: q holds its value and q_valid = 0.
- en=0: no access. q holds its last value and q_valid = 0.
- Out-of-range address (addr >= DEPTH):
  - Writes are dropped.
  - Reads return all zeros with q_valid = 1.
  - Timing is the same as a legal read.
- q is stable between valid strobes. Only a valid strobe updates q.

Optional Feature:
Macro RAM_PARITY_EN.
- Defined:
  - Each byte lane stores one extra even-parity bit, computed on write.
  - An output port parity_err (1 bit) is added. It is high together with q_valid when any read lane's stored parity mismatches.
  - parity_err resets to 0.
  - An input port par_inj (1 bit) is added. When high during a write, it inverts the stored parity of every enabled lane, for test.
  - The clear sequencer writes correct parity for zero data.
  - Out-of-range reads report parity_err = 0.
- Not defined: no extra storage, and neither port exists.

Test Plan:
1. Reset, then wait with CLEAR_ON_RESET=1, DEPTH=64 -> busy is high for exactly 64 cycles. Afterwards, a read of addr 0x3F returns 0x00000000 with q_valid.
2. Write 0xAABBCCDD, be=4'hF, addr 5; then write 0x11223344, be=4'b0101, addr 5; read addr 5 -> q = 0xAA22CC44. q_valid arrives 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
3. addr 7 holds 0x01020304; write 0xFFFFFFFF with be=4'hF to addr 7 in each RDW mode -> READ_FIRST q = 0x01020304 valid; WRITE_FIRST q = 0xFFFFFFFF valid; NO_CHANGE q unchanged with q_valid = 0.
4. Pulse rst_n low at clear pointer 30; release -> clear restarts at 0, busy lasts 64 more cycles, and a previously written word reads as 0.
5. DEPTH=48, ADDR_WIDTH=6: write 0x12345678 to addr 50, then read addr 50 -> q = 0 with q_valid. Read addr 47 -> its contents are unchanged.
6. RAM_PARITY_EN defined: write 0x000000FF to addr 3 with par_inj=1 and be=4'b0001, then read addr 3 -> parity_err = 1 with q_valid, q = 0x000000FF. Rewrite with par_inj=0, then read -> parity_err = 0.

Source files
------------

// File: rtl/single_port_ram_be.sv
`default_nettype none
// ============================================================================
// Module   : single_port_ram_be
// Brief    : Single-port synchronous RAM with byte enables, selectable
//            read-during-write mode, optional output register and post-reset
//            zero-fill. Optional per-lane parity under macro RAM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module single_port_ram_be #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 64,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data,
`ifdef RAM_PARITY_EN
    input  logic                    par_inj,
    output logic                    parity_err,
`endif
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    q_valid,
    output logic                    busy
);

    localparam int                    c_NB      = DATA_WIDTH / 8;
    localparam int                    c_IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   c_DEPTH   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST    = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [0:0]            c_S_INIT  = 1'b0;
    localparam logic [0:0]            c_S_RUN   = 1'b1;
    localparam logic [0:0]            c_S_RESET = (CLEAR_ON_RESET != 0) ? c_S_INIT : c_S_RUN;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_RESET;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (r_state == c_S_INIT) begin
            w_ptr_nxt = r_ptr + ADDR_WIDTH'(1);
            if (r_ptr == c_LAST) begin
                w_state_nxt = c_S_RUN;
                w_ptr_nxt   = '0;
            end
        end
    end

    assign busy = (r_state == c_S_INIT);

    // ------------------------------------------------------------------
    // Storage; the clear sequencer shares the single write port
    // ------------------------------------------------------------------
    logic                  w_in_range;
    logic                  w_wr_req;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [c_NB-1:0]       w_lane_we;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    assign w_in_range = ({1'b0, addr} < c_DEPTH);
    assign w_wr_req   = !busy && en && we;
    assign w_wr_addr  = busy ? r_ptr : addr;
    assign w_wr_data  = busy ? '0 : data;
    assign w_lane_we  = busy ? '1 : ((w_wr_req && w_in_range) ? be : '0);

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NB; i++) begin
            if (w_lane_we[i]) begin
                r_mem[w_wr_addr[c_IW-1:0]][8*i +: 8] <= w_wr_data[8*i +: 8];
            end
        end
    end

    // Old word and byte-merged new word; out-of-range accesses read as zero
    logic [DATA_WIDTH-1:0] w_old_word;
    logic [DATA_WIDTH-1:0] w_new_word;

    always_comb begin
        w_old_word = w_in_range ? r_mem[addr[c_IW-1:0]] : '0;
        w_new_word = w_old_word;
        for (int i = 0; i < c_NB; i++) begin
            if (be[i]) begin
                w_new_word[8*i +: 8] = data[8*i +: 8];
            end
        end
        if (!w_in_range) begin
            w_new_word = '0;
        end
    end

    // ------------------------------------------------------------------
    // First read stage: q only moves on a valid strobe
    // ------------------------------------------------------------------
    logic                  w_s1_valid;
    logic [DATA_WIDTH-1:0] w_s1_data;
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_q1;

    always_comb begin
        w_s1_valid = 1'b0;
        w_s1_data  = w_old_word;
        if (!busy && en) begin
            if (!we || RDW_MODE == 0) begin
                w_s1_valid = 1'b1;
            end else if (RDW_MODE == 1) begin
                w_s1_valid = 1'b1;
                w_s1_data  = w_new_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_q1 <= '0;
        end else begin
            r_v1 <= w_s1_valid;
            if (w_s1_valid) begin
                r_q1 <= w_s1_data;
            end
        end
    end

`ifdef RAM_PARITY_EN
    // ------------------------------------------------------------------
    // Even parity, one bit per byte lane
    // ------------------------------------------------------------------
    function automatic logic [c_NB-1:0] lane_parity(input logic [DATA_WIDTH-1:0] word);
        logic [c_NB-1:0] p;
        p = '0;
        for (int i = 0; i < c_NB; i++) begin
            p[i] = ^word[8*i +: 8];
        end
        return p;
    endfunction

    logic [c_NB-1:0] r_par [DEPTH];
    logic [c_NB-1:0] w_wr_par;
    logic [c_NB-1:0] w_old_par;
    logic [c_NB-1:0] w_new_par;
    logic [c_NB-1:0] w_s1_par;
    logic            w_s1_perr;
    logic            r_perr1;

    assign w_wr_par = lane_parity(w_wr_data) ^ {c_NB{par_inj && !busy}};

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_NB; i++) begin
            if (w_lane_we[i]) begin
                r_par[w_wr_addr[c_IW-1:0]][i] <= w_wr_par[i];
            end
        end
    end

    always_comb begin
        w_old_par = w_in_range ? r_par[addr[c_IW-1:0]] : '0;
        w_new_par = w_old_par;
        for (int i = 0; i < c_NB; i++) begin
            if (be[i]) begin
                w_new_par[i] = w_wr_par[i];
            end
        end
        if (!w_in_range) begin
            w_new_par = '0;
        end
        w_s1_par  = (we && RDW_MODE == 1) ? w_new_par : w_old_par;
        w_s1_perr = w_s1_valid && (|(w_s1_par ^ lane_parity(w_s1_data)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr1 <= 1'b0;
        end else begin
            r_perr1 <= w_s1_perr;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Optional output register stage
    // ------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_v2;
            logic [DATA_WIDTH-1:0] r_q2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v2 <= 1'b0;
                    r_q2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_q2 <= r_q1;
                    end
                end
            end

            assign q       = r_q2;
            assign q_valid = r_v2;
`ifdef RAM_PARITY_EN
            logic r_perr2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_perr2 <= 1'b0;
                end else begin
                    r_perr2 <= r_perr1;
                end
            end

            assign parity_err = r_perr2;
`endif
        end else begin : g_no_out_reg
            assign q       = r_q1;
            assign q_valid = r_v1;
`ifdef RAM_PARITY_EN
            assign parity_err = r_perr1;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_single_port_ram_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_single_port_ram_be
// Brief    : Directed, table-driven bench driving three RAM configurations
//            (READ_FIRST/64, WRITE_FIRST+OUT_REG/64, NO_CHANGE/48 no clear)
//            from one shared stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_single_port_ram_be;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] q0, q1, q2;
    logic        v0, v1, v2;
    logic        busy0, busy1, busy2;
`ifdef RAM_PARITY_EN
    logic        par_inj;
    logic        perr0, perr1, perr2;
`endif

    int total = 0;
    int bad   = 0;

    single_port_ram_be #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(64),
        .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .data(data),
`ifdef RAM_PARITY_EN
        .par_inj(par_inj), .parity_err(perr0),
`endif
        .q(q0), .q_valid(v0), .busy(busy0)
    );

    single_port_ram_be #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(64),
        .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .data(data),
`ifdef RAM_PARITY_EN
        .par_inj(par_inj), .parity_err(perr1),
`endif
        .q(q1), .q_valid(v1), .busy(busy1)
    );

    single_port_ram_be #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(48),
        .RDW_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(0)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr), .data(data),
`ifdef RAM_PARITY_EN
        .par_inj(par_inj), .parity_err(perr2),
`endif
        .q(q2), .q_valid(v2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        en;
        logic        we;
        logic [3:0]  be;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [31:0] eq0;
        logic        ev0;
        logic [31:0] eq1;
        logic        ev1;
        logic [31:0] eq2;
        logic        ev2;
    } vec_t;

    localparam int N_VEC = 18;
    vec_t vecs [N_VEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic w, input logic [3:0] b,
                                input logic [5:0] a, input logic [31:0] d,
                                input logic [31:0] x0, input logic y0,
                                input logic [31:0] x1, input logic y1,
                                input logic [31:0] x2, input logic y2);
        vec_t r;
        r.en = e; r.we = w; r.be = b; r.addr = a; r.data = d;
        r.eq0 = x0; r.ev0 = y0; r.eq1 = x1; r.ev1 = y1; r.eq2 = x2; r.ev2 = y2;
        return r;
    endfunction

    task automatic idle();
        en = 1'b0; we = 1'b0; be = 4'h0; addr = 6'd0; data = 32'h0;
`ifdef RAM_PARITY_EN
        par_inj = 1'b0;
`endif
    endtask

    // Counts rising edges until the clearing configurations drop busy
    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (busy0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, " busy0 cycles"}, n, 64);
        chk({name, " busy1 low"}, {31'd0, busy1}, 0);
    endtask

    initial begin
        // expected q/q_valid per configuration (dut1 observed one edge later)
        vecs[0]  = mk(1, 0, 4'h0, 6'h3F, 32'h0,        32'h0,        1, 32'h0,        1, 32'h0,        1);
        vecs[1]  = mk(1, 1, 4'hF, 6'd5,  32'hAABBCCDD, 32'h0,        1, 32'hAABBCCDD, 1, 32'h0,        0);
        vecs[2]  = mk(1, 1, 4'h5, 6'd5,  32'h11223344, 32'hAABBCCDD, 1, 32'hAA22CC44, 1, 32'h0,        0);
        vecs[3]  = mk(1, 0, 4'h0, 6'd5,  32'h0,        32'hAA22CC44, 1, 32'hAA22CC44, 1, 32'hAA22CC44, 1);
        vecs[4]  = mk(0, 0, 4'h0, 6'd5,  32'h0,        32'hAA22CC44, 0, 32'hAA22CC44, 0, 32'hAA22CC44, 0);
        vecs[5]  = mk(1, 1, 4'hF, 6'd7,  32'h01020304, 32'h0,        1, 32'h01020304, 1, 32'hAA22CC44, 0);
        vecs[6]  = mk(1, 1, 4'hF, 6'd7,  32'hFFFFFFFF, 32'h01020304, 1, 32'hFFFFFFFF, 1, 32'hAA22CC44, 0);
        vecs[7]  = mk(1, 0, 4'h0, 6'd7,  32'h0,        32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1);
        vecs[8]  = mk(1, 1, 4'hF, 6'd50, 32'h12345678, 32'h0,        1, 32'h12345678, 1, 32'hFFFFFFFF, 0);
        vecs[9]  = mk(1, 0, 4'h0, 6'd50, 32'h0,        32'h12345678, 1, 32'h12345678, 1, 32'h0,        1);
        vecs[10] = mk(1, 1, 4'hF, 6'd47, 32'hCAFEF00D, 32'h0,        1, 32'hCAFEF00D, 1, 32'h0,        0);
        vecs[11] = mk(1, 1, 4'hF, 6'd48, 32'hDEADBEEF, 32'h0,        1, 32'hDEADBEEF, 1, 32'h0,        0);
        vecs[12] = mk(1, 0, 4'h0, 6'd47, 32'h0,        32'hCAFEF00D, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1);
        vecs[13] = mk(1, 0, 4'h0, 6'd48, 32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 32'h0,        1);
        vecs[14] = mk(1, 1, 4'h0, 6'd5,  32'hFFFFFFFF, 32'hAA22CC44, 1, 32'hAA22CC44, 1, 32'h0,        0);
        vecs[15] = mk(1, 0, 4'h0, 6'd5,  32'h0,        32'hAA22CC44, 1, 32'hAA22CC44, 1, 32'hAA22CC44, 1);
        vecs[16] = mk(0, 1, 4'hF, 6'd5,  32'h0,        32'hAA22CC44, 0, 32'hAA22CC44, 0, 32'hAA22CC44, 0);
        vecs[17] = mk(1, 0, 4'h0, 6'd5,  32'h0,        32'hAA22CC44, 1, 32'hAA22CC44, 1, 32'hAA22CC44, 1);

        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst q0", q0, 0);
        chk("rst v0", {31'd0, v0}, 0);
        chk("rst q1", q1, 0);
        chk("rst v1", {31'd0, v1}, 0);
        chk("rst busy0", {31'd0, busy0}, 1);
        chk("rst busy2", {31'd0, busy2}, 0);
`ifdef RAM_PARITY_EN
        chk("rst perr0", {31'd0, perr0}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("clear1");

        for (int k = 0; k < N_VEC; k++) begin
            @(negedge clk);
            en = vecs[k].en; we = vecs[k].we; be = vecs[k].be;
            addr = vecs[k].addr; data = vecs[k].data;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d q0", k), q0, vecs[k].eq0);
            chk($sformatf("v%0d v0", k), {31'd0, v0}, {31'd0, vecs[k].ev0});
            chk($sformatf("v%0d q2", k), q2, vecs[k].eq2);
            chk($sformatf("v%0d v2", k), {31'd0, v2}, {31'd0, vecs[k].ev2});
            if (k > 0) begin
                chk($sformatf("v%0d q1", k - 1), q1, vecs[k-1].eq1);
                chk($sformatf("v%0d v1", k - 1), {31'd0, v1}, {31'd0, vecs[k-1].ev1});
            end
        end
        @(negedge clk);
        idle();
        @(posedge clk);
        #1;
        chk($sformatf("v%0d q1", N_VEC - 1), q1, vecs[N_VEC-1].eq1);
        chk($sformatf("v%0d v1", N_VEC - 1), {31'd0, v1}, {31'd0, vecs[N_VEC-1].ev1});

        // Asynchronous reset clears q without a clock edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async q0", q0, 0);
        chk("async q1", q1, 0);
        chk("async q2", q2, 0);
        chk("async busy0", {31'd0, busy0}, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Interrupt the zero-fill at pointer 30 and restart it
        repeat (30) @(posedge clk);
        #2;
        chk("mid busy0", {31'd0, busy0}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid rst busy0", {31'd0, busy0}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("clear2");

        // Word 5 was cleared in the 64-deep parts but survives in the no-clear part
        @(negedge clk);
        en = 1'b1; we = 1'b0; addr = 6'd5;
        @(posedge clk);
        #1;
        chk("post clr q0", q0, 0);
        chk("post clr v0", {31'd0, v0}, 1);
        chk("post clr q2", q2, 32'hAA22CC44);
        @(negedge clk);
        idle();
        @(posedge clk);
        #1;
        chk("post clr q1", q1, 0);
        chk("post clr v1", {31'd0, v1}, 1);
        chk("post clr v0 idle", {31'd0, v0}, 0);

`ifdef RAM_PARITY_EN
        @(negedge clk);
        en = 1'b1; we = 1'b1; be = 4'b0001; addr = 6'd3; data = 32'h000000FF; par_inj = 1'b1;
        @(negedge clk);
        we = 1'b0; be = 4'h0; par_inj = 1'b0;
        @(posedge clk);
        #1;
        chk("par inj q0", q0, 32'h000000FF);
        chk("par inj v0", {31'd0, v0}, 1);
        chk("par inj err0", {31'd0, perr0}, 1);
        @(negedge clk);
        we = 1'b1; be = 4'b0001; data = 32'h000000FF;
        @(negedge clk);
        we = 1'b0; be = 4'h0;
        @(posedge clk);
        #1;
        chk("par ok q0", q0, 32'h000000FF);
        chk("par ok err0", {31'd0, perr0}, 0);
        @(negedge clk);
        idle();
        @(posedge clk);
        #1;
        chk("par idle err0", {31'd0, perr0}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
